// File: rtl/tx_gearbox_pkg.sv
// ---------------------------------------------------------------------------
// tx_gearbox_pkg
// Shared definitions for the TX 66->32 gearbox write-side controller:
//   BLOCK_W     width of one encoded 64b/66b block
//   IDLE_BLOCK  control-header block carrying eight idle characters
//   gb_state_e  controller FSM states
//   gray2bin    Gray to binary conversion (up to 32 bits, upper bits zero)
// ---------------------------------------------------------------------------
package tx_gearbox_pkg;

  localparam int BLOCK_W = 66;

  // Sync header 2'b01 (control), block type 0x1E, all-idle payload.
  localparam logic [BLOCK_W-1:0] IDLE_BLOCK = {56'h0, 8'h1E, 2'b01};

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_PRIME   = 2'd1,
    ST_RUN     = 2'd2,
    ST_RECOVER = 2'd3
  } gb_state_e;

  // Each binary bit is the XOR of all Gray bits at or above it; the
  // shift-and-fold form does that in log2(32) steps.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int s = 1; s < 32; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// ---------------------------------------------------------------------------
// gray_ptr_sync
// Brings a Gray-coded pointer from a foreign clock domain into clk through a
// two-flop synchronizer and converts it to binary.
// Ports:
//   clk      destination clock
//   reset_n  asynchronous active-low reset (synchronizer flops clear to 0)
//   ptr_g    Gray-coded pointer, asynchronous to clk
//   ptr_bin  synchronized binary pointer (two cycles stale)
// ---------------------------------------------------------------------------
module gray_ptr_sync
  import tx_gearbox_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] ptr_g,
  output logic [W-1:0] ptr_bin
);

  logic [W-1:0] sync_p0;
  logic [W-1:0] sync_p1;

  // Stage p0: first capture of the asynchronous pointer (may go metastable)
  // Stage p1: settled copy used by the conversion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= ptr_g;
      sync_p1 <= sync_p0;
    end
  end

  assign ptr_bin = W'(gray2bin(32'(sync_p1)));

endmodule

// File: rtl/tx_gearbox_ctrl.sv
// ---------------------------------------------------------------------------
// tx_gearbox_ctrl
// Write-side controller for the TX 66->32 async gearbox. Holds the gearbox in
// reset, primes it with idle blocks, then forwards encoded blocks while
// watching occupancy (local write count minus synchronized read count).
// Underrun, overflow or a forced request restarts the gearbox.
//
// Build option: define TX_GB_CTRL_STATS_EN to keep the saturating restart
// counter; without it restart_cnt is constant 0.
//
// Ports:
//   clk            156.25 MHz block clock
//   reset_n        asynchronous active-low reset
//   enc_data       encoded block from the scrambler (sync header in [1:0])
//   enc_valid      enc_data valid
//   enc_ready      block accepted this cycle (high while in RUN)
//   gb_data        block to the gearbox write port
//   gb_valid       gearbox write strobe
//   gb_reset       active-high gearbox reset
//   rd_ptr_g       Gray-coded gearbox read row count (async to clk)
//   force_restart  one-cycle restart request (honoured in PRIME/RUN)
//   link_up        high while in RUN
//   err_underrun   one-cycle pulse on entering RECOVER for underrun
//   err_overflow   one-cycle pulse on entering RECOVER for overflow
//   restart_cnt    saturating count of error-caused restarts
// ---------------------------------------------------------------------------
module tx_gearbox_ctrl
  import tx_gearbox_pkg::*;
#(
  parameter int  GB_DEPTH     = 4,
  parameter int  HOLD_CYCLES  = 16,
  parameter int  PRIME_CYCLES = 32,
  localparam int PW           = $clog2(GB_DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [BLOCK_W-1:0] enc_data,
  input  logic               enc_valid,
  output logic               enc_ready,
  output logic [BLOCK_W-1:0] gb_data,
  output logic               gb_valid,
  output logic               gb_reset,
  input  logic [PW:0]        rd_ptr_g,
  input  logic               force_restart,
  output logic               link_up,
  output logic               err_underrun,
  output logic               err_overflow,
  output logic [7:0]         restart_cnt
);

  localparam int CNT_MAX = (HOLD_CYCLES > PRIME_CYCLES) ? HOLD_CYCLES : PRIME_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [PW:0] DEPTH_OCC = (PW+1)'(GB_DEPTH);

  gb_state_e        state;
  gb_state_e        state_nxt;
  logic [CNT_W-1:0] cyc_cnt;
  logic [PW:0]      wr_cnt;
  logic [PW:0]      rd_cnt;
  logic [PW:0]      occ;
  logic             ovf_det;
  logic             unf_det;

  gray_ptr_sync #(
    .W (PW+1)
  ) u_rd_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .ptr_g   (rd_ptr_g),
    .ptr_bin (rd_cnt)
  );

  // Modular difference; the read side is seen two cycles late, so this
  // over-reports occupancy and that bias is deliberately left in.
  assign occ = wr_cnt - rd_cnt;

  always_comb begin
    state_nxt = state;
    ovf_det   = 1'b0;
    unf_det   = 1'b0;
    case (state)
      ST_HOLD: begin
        if (cyc_cnt == CNT_W'(HOLD_CYCLES - 1)) state_nxt = ST_PRIME;
      end
      ST_PRIME: begin
        if (force_restart) begin
          state_nxt = ST_HOLD;
        end else if (cyc_cnt == CNT_W'(PRIME_CYCLES - 1)) begin
          // Overflow is tested first so it wins any tie.
          if (occ >= DEPTH_OCC) begin
            ovf_det   = 1'b1;
            state_nxt = ST_RECOVER;
          end else if (occ == '0) begin
            unf_det   = 1'b1;
            state_nxt = ST_RECOVER;
          end else begin
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (force_restart) begin
          state_nxt = ST_HOLD;
        end else if (occ >= DEPTH_OCC) begin
          ovf_det   = 1'b1;
          state_nxt = ST_RECOVER;
        end else if (occ == '0) begin
          unf_det   = 1'b1;
          state_nxt = ST_RECOVER;
        end
      end
      ST_RECOVER: state_nxt = ST_HOLD;
      default:    state_nxt = ST_HOLD;
    endcase
  end

  // Stage p0: state, counters and every control output registered from the
  // state being entered, so outputs change on the same edge as the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_HOLD;
      cyc_cnt      <= '0;
      wr_cnt       <= '0;
      gb_reset     <= 1'b1;
      gb_valid     <= 1'b0;
      enc_ready    <= 1'b0;
      link_up      <= 1'b0;
      err_underrun <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cyc_cnt <= '0;
      end else if (state == ST_HOLD || state == ST_PRIME) begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
      // Counts completed gearbox writes; cleared for the whole HOLD period
      // so a fresh PRIME always starts from row 0.
      if (state == ST_HOLD) begin
        wr_cnt <= '0;
      end else begin
        wr_cnt <= wr_cnt + (PW+1)'(gb_valid);
      end
      gb_reset     <= (state_nxt == ST_HOLD);
      gb_valid     <= (state_nxt == ST_PRIME) || (state_nxt == ST_RUN);
      enc_ready    <= (state_nxt == ST_RUN);
      link_up      <= (state_nxt == ST_RUN);
      err_underrun <= unf_det;
      err_overflow <= ovf_det;
    end
  end

  // Stage p0 data: enc_ready mirrors "currently in RUN", so a block is taken
  // only when it was offered while the controller advertised ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gb_data <= '0;
    end else if (state_nxt == ST_RUN) begin
      gb_data <= (enc_ready && enc_valid) ? enc_data : IDLE_BLOCK;
    end else if (state_nxt == ST_PRIME) begin
      gb_data <= IDLE_BLOCK;
    end else begin
      gb_data <= '0;
    end
  end

`ifdef TX_GB_CTRL_STATS_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] restart_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      restart_cnt_q <= '0;
    end else if (ovf_det || unf_det) begin
      restart_cnt_q <= sat_inc8(restart_cnt_q);
    end
  end

  assign restart_cnt = restart_cnt_q;
`else
  assign restart_cnt = 8'h00;
`endif

endmodule
